// File: rtl/fetch_ctrl_pkg.sv
// Shared types and helpers for the fetch redirect sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        REDIRECT,
        FLUSH
    } redir_state_e;

    localparam int CNT_W      = 4;
    localparam int AGE_CALC_W = 16;

    // Distance from the ROB head, modulo 2^tag_w; tags up to AGE_CALC_W bits.
    function automatic logic [AGE_CALC_W-1:0] rob_age(
        input logic [AGE_CALC_W-1:0] tag,
        input logic [AGE_CALC_W-1:0] head,
        input int unsigned           tag_w
    );
        logic [AGE_CALC_W-1:0] mask;
        mask = (AGE_CALC_W'(1) << tag_w) - AGE_CALC_W'(1);
        return (tag - head) & mask;
    endfunction

endpackage

// File: rtl/fetch_redirect_arbiter_picker.sv
// Combinational oldest-by-ROB-age selector; ties resolve to the lower index.
module redirect_age_picker
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0]       valid,
    input  logic [NUM_SRC*TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]         head,
    output logic [NUM_SRC-1:0]       oldest,
    output logic [TAG_W-1:0]         oldest_age
);

    logic             found;
    logic [TAG_W-1:0] age_k;

    always_comb begin
        oldest     = '0;
        oldest_age = '0;
        found      = 1'b0;
        age_k      = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            age_k = TAG_W'(rob_age(AGE_CALC_W'(tags[k*TAG_W +: TAG_W]),
                                   AGE_CALC_W'(head), TAG_W));
            if (valid[k] && (!found || age_k < oldest_age)) begin
                oldest     = '0;
                oldest[k]  = 1'b1;
                oldest_age = age_k;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_redirect_arbiter.sv
// Redirect sequencer: picks the oldest redirect, pulses the PC controller and
// back-end flush, then holds fetch for a window that older redirects may restart.
module fetch_redirect_arbiter
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned TAG_W        = 5,
    parameter int unsigned NUM_SRC      = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        redir_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] redir_pc_i,
    input  logic [NUM_SRC*TAG_W-1:0]  redir_tag_i,
    input  logic [TAG_W-1:0]          head_tag_i,
    input  logic                      fetch_stall_i,
    output logic [NUM_SRC-1:0]        redir_ack_o,
    output logic                      misprediction,
    output logic [ADDR_W-1:0]         correct_pc,
    output logic                      buble,
    output logic                      flush_o,
    output logic [TAG_W-1:0]          flush_tag_o
);

    redir_state_e       state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] oldest;
    logic [TAG_W-1:0]   oldest_age;
    logic [TAG_W-1:0]   cap_age;
    logic [ADDR_W-1:0]  pick_pc;
    logic [TAG_W-1:0]   pick_tag;
    logic               any_valid;
    logic               preempt;

    redirect_age_picker #(
        .TAG_W   (TAG_W),
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .valid      (redir_valid_i),
        .tags       (redir_tag_i),
        .head       (head_tag_i),
        .oldest     (oldest),
        .oldest_age (oldest_age)
    );

    always_comb begin
        pick_pc  = '0;
        pick_tag = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (oldest[k]) begin
                pick_pc  = pick_pc  | redir_pc_i[k*ADDR_W +: ADDR_W];
                pick_tag = pick_tag | redir_tag_i[k*TAG_W +: TAG_W];
            end
        end
    end

    // The in-flight redirect's age is re-evaluated against the live head every cycle.
    assign cap_age   = TAG_W'(rob_age(AGE_CALC_W'(flush_tag_o), AGE_CALC_W'(head_tag_i), TAG_W));
    assign any_valid = |redir_valid_i;
    assign preempt   = any_valid && (oldest_age < cap_age);

    always_comb begin
        redir_ack_o = '0;
        if (reset) begin
            if (state == RUN) redir_ack_o = oldest;
            else              redir_ack_o = redir_valid_i;
        end
    end

    assign buble = !reset || (state != RUN) || fetch_stall_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            cnt           <= '0;
            misprediction <= 1'b0;
            flush_o       <= 1'b0;
            correct_pc    <= '0;
            flush_tag_o   <= '0;
        end else begin
            misprediction <= 1'b0;
            flush_o       <= 1'b0;
            case (state)
                RUN: begin
                    if (any_valid) begin
                        correct_pc    <= pick_pc;
                        flush_tag_o   <= pick_tag;
                        misprediction <= 1'b1;
                        flush_o       <= 1'b1;
                        state         <= REDIRECT;
                    end
                end
                REDIRECT, FLUSH: begin
                    if (state == REDIRECT) begin
                        cnt   <= CNT_W'(FLUSH_CYCLES);
                        state <= FLUSH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= RUN;
                    end
                    // An older redirect overrides whatever the window would have done.
                    if (preempt) begin
                        correct_pc    <= pick_pc;
                        flush_tag_o   <= pick_tag;
                        misprediction <= 1'b1;
                        flush_o       <= 1'b1;
                        state         <= REDIRECT;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// Bench for fetch_redirect_arbiter: directed scenarios plus random traffic
// checked every cycle against a hold-countdown reference model.
module tb_fetch_redirect_arbiter;

    localparam int ADDR_W  = 32;
    localparam int TAG_W   = 5;
    localparam int NUM_SRC = 3;
    localparam int FC      = 2;
    localparam int TAG_MOD = 1 << TAG_W;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_SRC-1:0]        redir_valid_i = '0;
    logic [NUM_SRC*ADDR_W-1:0] redir_pc_i = '0;
    logic [NUM_SRC*TAG_W-1:0]  redir_tag_i = '0;
    logic [TAG_W-1:0]          head_tag_i = '0;
    logic                      fetch_stall_i = 1'b0;
    logic [NUM_SRC-1:0]        redir_ack_o;
    logic                      misprediction;
    logic [ADDR_W-1:0]         correct_pc;
    logic                      buble;
    logic                      flush_o;
    logic [TAG_W-1:0]          flush_tag_o;

    fetch_redirect_arbiter #(
        .ADDR_W       (ADDR_W),
        .TAG_W        (TAG_W),
        .NUM_SRC      (NUM_SRC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .redir_tag_i   (redir_tag_i),
        .head_tag_i    (head_tag_i),
        .fetch_stall_i (fetch_stall_i),
        .redir_ack_o   (redir_ack_o),
        .misprediction (misprediction),
        .correct_pc    (correct_pc),
        .buble         (buble),
        .flush_o       (flush_o),
        .flush_tag_o   (flush_tag_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: remaining fetch-hold cycles, pending pulse, captured redirect.
    int          m_hold  = 0;
    bit          m_pulse = 1'b0;
    logic [31:0] m_pc    = '0;
    int          m_tag   = 0;

    logic [31:0] pc_a  [NUM_SRC];
    int          tag_a [NUM_SRC];
    int          head_nx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int age_of(input int tag, input int head);
        return ((tag - head) % TAG_MOD + TAG_MOD) % TAG_MOD;
    endfunction

    function automatic int src_tag(input int k);
        return int'(redir_tag_i[k*TAG_W +: TAG_W]);
    endfunction

    function automatic int oldest_idx();
        int best;
        best = -1;
        for (int k = 0; k < NUM_SRC; k++)
            if (redir_valid_i[k] &&
                (best < 0 || age_of(src_tag(k), head_tag_i) < age_of(src_tag(best), head_tag_i)))
                best = k;
        return best;
    endfunction

    task automatic model_cycle();
        logic [NUM_SRC-1:0] e_ack;
        int o;
        if (!reset) begin
            check("rst_ack", redir_ack_o, 0);
            check("rst_buble", buble, 1);
            check("rst_mis", misprediction, 0);
            check("rst_flush", flush_o, 0);
            check("rst_pc", correct_pc, 0);
            check("rst_tag", flush_tag_o, 0);
            m_hold = 0; m_pulse = 1'b0; m_pc = '0; m_tag = 0;
            return;
        end
        o = oldest_idx();
        e_ack = '0;
        if (m_hold == 0) begin
            if (o >= 0) e_ack[o] = 1'b1;
        end else begin
            e_ack = redir_valid_i;
        end
        check("ack", redir_ack_o, e_ack);
        check("buble", buble, (m_hold > 0) || fetch_stall_i);
        check("mis", misprediction, m_pulse);
        check("flush", flush_o, m_pulse);
        if (m_pulse) begin
            check("correct_pc", correct_pc, m_pc);
            check("flush_tag", flush_tag_o, m_tag);
        end
        m_pulse = 1'b0;
        if (m_hold == 0) begin
            if (o >= 0) begin
                m_pc = redir_pc_i[o*ADDR_W +: ADDR_W]; m_tag = src_tag(o);
                m_pulse = 1'b1; m_hold = FC + 1;
            end
        end else begin
            m_hold--;
            if (o >= 0 && age_of(src_tag(o), head_tag_i) < age_of(m_tag, head_tag_i)) begin
                m_pc = redir_pc_i[o*ADDR_W +: ADDR_W]; m_tag = src_tag(o);
                m_pulse = 1'b1; m_hold = FC + 1;
            end
        end
    endtask

    task automatic step(input bit rst, input logic [NUM_SRC-1:0] v, input bit stall);
        @(posedge clk);
        #1;
        reset         = rst;
        redir_valid_i = v;
        fetch_stall_i = stall;
        head_tag_i    = TAG_W'(head_nx);
        for (int k = 0; k < NUM_SRC; k++) begin
            redir_pc_i[k*ADDR_W +: ADDR_W] = pc_a[k];
            redir_tag_i[k*TAG_W +: TAG_W]  = TAG_W'(tag_a[k]);
        end
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < NUM_SRC; k++) begin pc_a[k] = '0; tag_a[k] = 0; end
        step(1'b0, '0, 1'b0);
        step(1'b0, 3'b111, 1'b0);
        check("reset_ack_lit", redir_ack_o, 3'b000);
        check("reset_buble_lit", buble, 1);
        idle(2);

        // Single redirect
        head_nx = 0; pc_a[1] = 32'h100; tag_a[1] = 3;
        step(1'b1, 3'b010, 1'b0);
        check("single_ack", redir_ack_o, 3'b010);
        step(1'b1, 3'b000, 1'b0);
        check("single_mis", misprediction, 1);
        check("single_flush", flush_o, 1);
        check("single_pc", correct_pc, 32'h100);
        check("single_tag", flush_tag_o, 3);
        check("single_buble1", buble, 1);
        step(1'b1, 3'b000, 1'b0);
        check("single_mis_off", misprediction, 0);
        check("single_buble2", buble, 1);
        step(1'b1, 3'b000, 1'b0);
        check("single_buble3", buble, 1);
        step(1'b1, 3'b000, 1'b0);
        check("single_run", buble, 0);
        idle(1);

        // Oldest select across tag wrap
        head_nx = 30; pc_a[0] = 32'h200; tag_a[0] = 2; pc_a[2] = 32'h300; tag_a[2] = 31;
        step(1'b1, 3'b101, 1'b0);
        check("wrap_ack", redir_ack_o, 3'b100);
        step(1'b1, 3'b001, 1'b0);
        check("wrap_drop_ack", redir_ack_o, 3'b001);
        check("wrap_pc", correct_pc, 32'h300);
        check("wrap_tag", flush_tag_o, 31);
        step(1'b1, 3'b000, 1'b0);
        check("wrap_no_preempt", misprediction, 0);
        idle(4);

        // Preemption restarts the window
        head_nx = 0; pc_a[1] = 32'h600; tag_a[1] = 6;
        step(1'b1, 3'b010, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        check("pre_first_pc", correct_pc, 32'h600);
        pc_a[0] = 32'h400; tag_a[0] = 4;
        step(1'b1, 3'b001, 1'b0);
        check("pre_ack", redir_ack_o, 3'b001);
        step(1'b1, 3'b000, 1'b0);
        check("pre_mis", misprediction, 1);
        check("pre_pc", correct_pc, 32'h400);
        check("pre_tag", flush_tag_o, 4);
        pc_a[2] = 32'h900; tag_a[2] = 9;
        step(1'b1, 3'b100, 1'b0);
        check("pre_young_ack", redir_ack_o, 3'b100);
        check("pre_young_mis", misprediction, 0);
        step(1'b1, 3'b000, 1'b0);
        check("pre_young_drop", misprediction, 0);
        check("pre_window", buble, 1);
        step(1'b1, 3'b000, 1'b0);
        check("pre_run", buble, 0);
        idle(1);

        // Equal-age tie
        pc_a[0] = 32'hA0; tag_a[0] = 5; pc_a[1] = 32'hB0; tag_a[1] = 5;
        step(1'b1, 3'b011, 1'b0);
        check("tie_ack", redir_ack_o, 3'b001);
        step(1'b1, 3'b000, 1'b0);
        check("tie_pc", correct_pc, 32'hA0);
        idle(4);

        // Redirect overrides stall
        pc_a[1] = 32'hC0; tag_a[1] = 1;
        step(1'b1, 3'b010, 1'b1);
        check("stall_ack", redir_ack_o, 3'b010);
        step(1'b1, 3'b000, 1'b1);
        check("stall_mis", misprediction, 1);
        check("stall_buble", buble, 1);
        step(1'b1, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b1);
        check("stall_follow1", buble, 1);
        step(1'b1, 3'b000, 1'b0);
        check("stall_follow0", buble, 0);

        // Reset mid-flush
        pc_a[0] = 32'hD0; tag_a[0] = 2;
        step(1'b1, 3'b001, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b0, 3'b111, 1'b0);
        check("midrst_ack", redir_ack_o, 0);
        check("midrst_mis", misprediction, 0);
        check("midrst_buble", buble, 1);
        check("midrst_pc", correct_pc, 0);
        step(1'b0, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        check("postrst_mis", misprediction, 0);
        check("postrst_buble", buble, 0);
        step(1'b1, 3'b000, 1'b0);
        check("postrst_mis2", misprediction, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_SRC-1:0] v;
            head_nx = int'($urandom_range(0, TAG_MOD - 1));
            for (int k = 0; k < NUM_SRC; k++) begin
                pc_a[k]  = $urandom;
                tag_a[k] = int'($urandom_range(0, TAG_MOD - 1));
                v[k]     = ($urandom_range(0, 3) == 0);
            end
            step($urandom_range(0, 199) != 0, v, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
